// File: rtl/serv_rf_dbg_arb.sv
// serv_rf_dbg_arb: shares the bit-serial SERV register-file port between the
// core and a word-wide debug port. A debug access becomes one RF request
// followed by a 32-cycle LSB-first burst. Core requests that arrive during a
// debug access are held and replayed once the arbiter returns to idle.
//
//   state  | meaning
//   IDLE   | core owns the RF port, debug access may be accepted
//   DREQ   | one-cycle RF read/write request on behalf of debug
//   DWAIT  | waiting for RF adapter ready
//   DSHIFT | 32 serial bit cycles, counter 0..31
//   DACK   | one-cycle debug acknowledge, read data valid
module serv_rf_dbg_arb #(
  parameter int WITH_CSR = 1,
  localparam int AW = 5 + WITH_CSR
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_core_active,
  input  logic          i_core_rreq,
  input  logic          i_core_wreq,
  output logic          o_core_ready,
  input  logic [AW-1:0] i_core_wreg0,
  input  logic [AW-1:0] i_core_wreg1,
  input  logic [AW-1:0] i_core_rreg0,
  input  logic [AW-1:0] i_core_rreg1,
  input  logic          i_core_wen0,
  input  logic          i_core_wen1,
  input  logic          i_core_wdata0,
  input  logic          i_core_wdata1,
  output logic          o_core_rdata0,
  output logic          o_core_rdata1,
  output logic          o_rf_rreq,
  output logic          o_rf_wreq,
  input  logic          i_rf_ready,
  output logic [AW-1:0] o_wreg0,
  output logic [AW-1:0] o_wreg1,
  output logic [AW-1:0] o_rreg0,
  output logic [AW-1:0] o_rreg1,
  output logic          o_wen0,
  output logic          o_wen1,
  output logic          o_wdata0,
  output logic          o_wdata1,
  input  logic          i_rdata0,
  input  logic          i_rdata1,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [31:0]   i_dbg_wdata,
  output logic          o_dbg_ack,
  output logic [31:0]   o_dbg_rdata
);

  typedef enum logic [2:0] {IDLE, DREQ, DWAIT, DSHIFT, DACK} state_t;

  state_t        state, state_nxt;
  logic [4:0]    cnt;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   shreg;
  logic [31:0]   rdata_q;
  logic          pend_r, pend_w;
  logic          accept;

  // Core always wins a tie, and held core requests must drain before debug.
  assign accept = (state == IDLE) & i_dbg_req & ~i_core_active & ~i_core_rreq
                & ~i_core_wreq & ~pend_r & ~pend_w;

  // State register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Debug datapath: request latch, bit counter, read shifter, pending core requests
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      d_we    <= 1'b0;
      d_addr  <= '0;
      d_wdata <= '0;
      shreg   <= '0;
      rdata_q <= '0;
      pend_r  <= 1'b0;
      pend_w  <= 1'b0;
    end else begin
      if (accept) begin
        d_we    <= i_dbg_we;
        d_addr  <= i_dbg_addr;
        d_wdata <= i_dbg_wdata;
      end
      if (state == DSHIFT) begin
        cnt <= cnt + 5'd1;
        if (!d_we) begin
          shreg <= {i_rdata0, shreg[31:1]};
          // last bit goes straight into the result so it is valid during DACK
          if (cnt == 5'd31) rdata_q <= {i_rdata0, shreg[31:1]};
        end
      end
      if (state != IDLE) begin
        pend_r <= pend_r | i_core_rreq;
        pend_w <= pend_w | i_core_wreq;
      end else if (pend_r) begin
        pend_r <= 1'b0;
      end else if (pend_w) begin
        pend_w <= 1'b0;
      end
    end
  end

  // Next state and RF/core port muxing by owner
  always_comb begin
    state_nxt     = state;
    o_core_ready  = 1'b0;
    o_core_rdata0 = 1'b0;
    o_core_rdata1 = 1'b0;
    o_rf_rreq     = 1'b0;
    o_rf_wreq     = 1'b0;
    o_wreg0       = d_addr;
    o_rreg0       = d_addr;
    o_wreg1       = '0;
    o_rreg1       = '0;
    o_wen0        = 1'b0;
    o_wen1        = 1'b0;
    o_wdata0      = 1'b0;
    o_wdata1      = 1'b0;
    o_dbg_ack     = 1'b0;
    case (state)
      IDLE: begin
        o_core_ready  = i_rf_ready;
        o_core_rdata0 = i_rdata0;
        o_core_rdata1 = i_rdata1;
        // replay held requests one per cycle, read first
        o_rf_rreq     = i_core_rreq | pend_r;
        o_rf_wreq     = i_core_wreq | (pend_w & ~pend_r);
        o_wreg0       = i_core_wreg0;
        o_wreg1       = i_core_wreg1;
        o_rreg0       = i_core_rreg0;
        o_rreg1       = i_core_rreg1;
        o_wen0        = i_core_wen0;
        o_wen1        = i_core_wen1;
        o_wdata0      = i_core_wdata0;
        o_wdata1      = i_core_wdata1;
        if (accept) state_nxt = DREQ;
      end
      DREQ: begin
        o_rf_rreq = ~d_we;
        o_rf_wreq = d_we;
        state_nxt = i_rf_ready ? DSHIFT : DWAIT;
      end
      DWAIT: begin
        if (i_rf_ready) state_nxt = DSHIFT;
      end
      DSHIFT: begin
        // x0 is hardwired zero, so the burst runs but never writes
        o_wen0   = d_we & (d_addr != '0);
        o_wdata0 = d_we & d_wdata[cnt];
        if (cnt == 5'd31) state_nxt = DACK;
      end
      DACK: begin
        o_dbg_ack = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_dbg_rdata = rdata_q;

endmodule

// File: tb/tb_serv_rf_dbg_arb.sv
// Bench for serv_rf_dbg_arb: an RF adapter/RAM model answers requests with a
// programmable latency, and a word-level register-file model predicts every
// debug read and the RAM contents after every debug write.
module tb_serv_rf_dbg_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_active, core_rreq, core_wreq;
  logic        o_core_ready;
  logic [5:0]  core_wreg0, core_wreg1, core_rreg0, core_rreg1;
  logic        core_wen0, core_wen1, core_wdata0, core_wdata1;
  logic        o_core_rdata0, o_core_rdata1;
  logic        o_rf_rreq, o_rf_wreq;
  logic        rf_ready;
  logic [5:0]  o_wreg0, o_wreg1, o_rreg0, o_rreg1;
  logic        o_wen0, o_wen1, o_wdata0, o_wdata1;
  logic        rf_rdata0, rf_rdata1;
  logic        dbg_req, dbg_we;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        o_dbg_ack;
  logic [31:0] o_dbg_rdata;

  always #5 clk = ~clk;

  serv_rf_dbg_arb #(.WITH_CSR(1)) dut (
    .clk(clk), .i_rst_n(rst_n),
    .i_core_active(core_active), .i_core_rreq(core_rreq), .i_core_wreq(core_wreq),
    .o_core_ready(o_core_ready),
    .i_core_wreg0(core_wreg0), .i_core_wreg1(core_wreg1),
    .i_core_rreg0(core_rreg0), .i_core_rreg1(core_rreg1),
    .i_core_wen0(core_wen0), .i_core_wen1(core_wen1),
    .i_core_wdata0(core_wdata0), .i_core_wdata1(core_wdata1),
    .o_core_rdata0(o_core_rdata0), .o_core_rdata1(o_core_rdata1),
    .o_rf_rreq(o_rf_rreq), .o_rf_wreq(o_rf_wreq), .i_rf_ready(rf_ready),
    .o_wreg0(o_wreg0), .o_wreg1(o_wreg1), .o_rreg0(o_rreg0), .o_rreg1(o_rreg1),
    .o_wen0(o_wen0), .o_wen1(o_wen1), .o_wdata0(o_wdata0), .o_wdata1(o_wdata1),
    .i_rdata0(rf_rdata0), .i_rdata1(rf_rdata1),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata), .o_dbg_ack(o_dbg_ack), .o_dbg_rdata(o_dbg_rdata)
  );

  // RF adapter + RAM model
  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];
  int          ad_st, ad_wait, ad_j, lat;
  logic [5:0]  ad_a;
  logic        ad_ready, tb_ready;
  logic        ld_en;
  logic [5:0]  ld_a;
  logic [31:0] ld_d;

  assign rf_ready  = ad_ready | tb_ready;
  assign rf_rdata1 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ad_st <= 0; ad_ready <= 1'b0; rf_rdata0 <= 1'b0; ad_wait <= 0; ad_j <= 0; ad_a <= '0;
    end else begin
      if (ld_en) ram[ld_a] <= ld_d;
      case (ad_st)
        0: if (o_rf_rreq || o_rf_wreq) begin
             ad_a    <= o_rf_wreq ? o_wreg0 : o_rreg0;
             ad_wait <= lat;
             ad_st   <= 1;
           end
        1: if (ad_wait == 0) begin ad_ready <= 1'b1; ad_st <= 2; end
           else ad_wait <= ad_wait - 1;
        2: begin ad_ready <= 1'b0; rf_rdata0 <= ram[ad_a][0]; ad_j <= 0; ad_st <= 3; end
        default: begin
          if (o_wen0) ram[o_wreg0][ad_j] <= o_wdata0;
          if (ad_j == 31) begin ad_st <= 0; rf_rdata0 <= 1'b0; end
          else begin rf_rdata0 <= ram[ad_a][ad_j+1]; ad_j <= ad_j + 1; end
        end
      endcase
    end
  end

  // Event counters on the RF and core sides
  int rreq_cnt = 0, wreq_cnt = 0, wen_cnt = 0, cr_cnt = 0, cd_cnt = 0;
  always @(posedge clk) begin
    if (o_rf_rreq)     rreq_cnt <= rreq_cnt + 1;
    if (o_rf_wreq)     wreq_cnt <= wreq_cnt + 1;
    if (o_wen0)        wen_cnt  <= wen_cnt + 1;
    if (o_core_ready)  cr_cnt   <= cr_cnt + 1;
    if (o_core_rdata0) cd_cnt   <= cd_cnt + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk); ld_en = 1'b1; ld_a = 6'(a); ld_d = d;
    @(negedge clk); ld_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // One debug access started at a negedge in IDLE; optional core pulses at cycles inj_r/inj_w.
  task automatic dbg_op(input bit we, input logic [5:0] a, input logic [31:0] wd,
                        input int l, input int inj_r, input int inj_w);
    int b_r, b_w, b_wen, b_cr, b_cd, cyc;
    bit got;
    logic [31:0] rd;
    lat = l;
    b_r = rreq_cnt; b_w = wreq_cnt; b_wen = wen_cnt; b_cr = cr_cnt; b_cd = cd_cnt;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    got = 1'b0; cyc = 0; rd = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      cyc = k;
      if (o_dbg_ack) begin got = 1'b1; rd = o_dbg_rdata; break; end
      if (k == 6) begin
        chk("port1_zero", 32'({o_wen1, o_wreg1, o_rreg1}), 32'd0);
        chk("dbg_addr_out", 32'(we ? o_wreg0 : o_rreg0), 32'(a));
      end
      core_rreq = (k == inj_r);
      core_wreq = (k == inj_w);
    end
    dbg_req = 1'b0; core_rreq = 1'b0; core_wreq = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(cyc), 32'(36 + l));
    if (!we) chk("dbg_rdata", rd, ref_mem[a]);
    chk("rf_wreq_pulses", 32'(wreq_cnt - b_w), 32'(we));
    chk("rf_rreq_pulses", 32'(rreq_cnt - b_r), 32'(!we));
    chk("wen0_cycles", 32'(wen_cnt - b_wen), (we && a != 0) ? 32'd32 : 32'd0);
    chk("core_ready_held", 32'(cr_cnt - b_cr), 32'd0);
    chk("core_rdata_zero", 32'(cd_cnt - b_cd), 32'd0);
    @(negedge clk);
    chk("replay1_rreq", 32'(o_rf_rreq), 32'(inj_r > 0));
    chk("replay1_wreq", 32'(o_rf_wreq), 32'(inj_w > 0 && inj_r == 0));
    @(negedge clk);
    chk("replay2_rreq", 32'(o_rf_rreq), 32'd0);
    chk("replay2_wreq", 32'(o_rf_wreq), 32'(inj_w > 0 && inj_r > 0));
    if (inj_r > 0 || inj_w > 0) repeat (45) @(negedge clk);
    if (we && a != 0) ref_mem[a] = wd;
    if (we) chk("ram_word", ram[a], ref_mem[a]);
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    int b_r;
    logic [31:0] wd;
    rst_n = 1'b0; core_active = 0; core_rreq = 0; core_wreq = 0;
    core_wreg0 = '0; core_wreg1 = '0; core_rreg0 = '0; core_rreg1 = '0;
    core_wen0 = 0; core_wen1 = 0; core_wdata0 = 0; core_wdata1 = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    tb_ready = 0; ld_en = 0; ld_a = '0; ld_d = '0; lat = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(o_dbg_ack), 32'd0);
    chk("rst_rdata", o_dbg_rdata, 32'd0);
    chk("rst_rreq", 32'(o_rf_rreq), 32'd0);
    chk("rst_wreq", 32'(o_rf_wreq), 32'd0);
    core_rreg0 = 6'd3; #1;
    chk("rst_rreg0_pass", 32'(o_rreg0), 32'd3);
    @(negedge clk); rst_n = 1'b1;
    tb_ready = 1'b1; core_wen1 = 1'b1; core_wreg1 = 6'h15; core_rreg1 = 6'h2A; #1;
    chk("idle_ready_pass", 32'(o_core_ready), 32'd1);
    chk("idle_wreg1_pass", 32'(o_wreg1), 32'h15);
    chk("idle_wen1_pass", 32'(o_wen1), 32'd1);
    tb_ready = 1'b0;

    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(34, 32'h80000004);

    // directed accesses
    dbg_op(1'b1, 6'd5, 32'hDEADBEEF, 0, 0, 0);
    dbg_op(1'b0, 6'd34, 32'h0, 0, 0, 0);
    dbg_op(1'b1, 6'd0, 32'hFFFFFFFF, 0, 0, 0);

    // core read and debug request in the same idle cycle
    @(negedge clk);
    b_r = rreq_cnt; lat = 0;
    core_active = 1'b1; core_rreq = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd34; #1;
    chk("tie_core_rreq", 32'(o_rf_rreq), 32'd1);
    chk("tie_core_addr", 32'(o_rreg0), 32'd3);
    @(negedge clk); core_rreq = 1'b0;
    repeat (40) @(negedge clk);
    chk("tie_dbg_held", 32'(rreq_cnt - b_r), 32'd1);
    core_active = 1'b0;
    dbg_op(1'b0, 6'd34, 32'h0, 0, 0, 0);

    // core pulses while debug owns the port
    dbg_op(1'b1, 6'd7, 32'h13579BDF, 1, 0, 10);
    dbg_op(1'b0, 6'd9, 32'h0, 2, 3, 20);

    // reset in the middle of a write burst
    @(negedge clk);
    lat = 0; wd = 32'hA5A5F00F;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd12; dbg_wdata = wd;
    repeat (21) @(negedge clk);
    chk("mid_wen0", 32'(o_wen0), 32'd1);
    rst_n = 1'b0; #1;
    chk("abort_wen0", 32'(o_wen0), 32'd0);
    chk("abort_ack", 32'(o_dbg_ack), 32'd0);
    chk("abort_wreq", 32'(o_rf_wreq), 32'd0);
    chk("abort_rreq", 32'(o_rf_rreq), 32'd0);
    dbg_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    ref_mem[12] = (ref_mem[12] & ~32'h0001FFFF) | (wd & 32'h0001FFFF);
    dbg_op(1'b0, 6'd12, 32'h0, 0, 0, 0);

    // randomized accesses
    for (int i = 0; i < 24; i++) begin
      dbg_op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
             int'($urandom_range(0, 3)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serv_rf_dbg_arb.md
Name: serv_rf_dbg_arb

Overview:
- Arbiter and sequencer for the bit-serial register-file port of the SERV core.
- Shares the RF RAM between the core (via its RF interface) and a word-wide debug access port.
- Debug reads and writes of GPRs and CSRs are serialised as 32-cycle LSB-first bursts on the same RF port the core uses.
- Sits between the core's RF interface and the RF RAM adapter.

Parameters:
- WITH_CSR, 1: CSRs present in the RF address space; address width AW = 5+WITH_CSR.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_core_active  in  1  core is mid-instruction (fetch to retire)
- i_core_rreq  in  1  core RF read request (1-cycle pulse)
- i_core_wreq  in  1  core RF write request (1-cycle pulse)
- o_core_ready  out  1  RF ready, forwarded to core
- i_core_wreg0, i_core_wreg1, i_core_rreg0, i_core_rreg1  in  AW each  core RF addresses
- i_core_wen0, i_core_wen1, i_core_wdata0, i_core_wdata1  in  1 each  core write strobes/data
- o_core_rdata0, o_core_rdata1  out  1 each  RF read bits to core
- o_rf_rreq, o_rf_wreq  out  1 each  requests to RF RAM adapter
- i_rf_ready  in  1  adapter ready; serial data starts the next cycle
- o_wreg0, o_wreg1, o_rreg0, o_rreg1  out  AW each  RF addresses
- o_wen0, o_wen1, o_wdata0, o_wdata1  out  1 each  RF write strobes/data
- i_rdata0, i_rdata1  in  1 each  RF read bits
- i_dbg_req  in  1  debug request (level, held until ack)
- i_dbg_we  in  1  1 = write, 0 = read
- i_dbg_addr  in  AW  RF address
- i_dbg_wdata  in  32  write data
- o_dbg_ack  out  1  1-cycle completion pulse
- o_dbg_rdata  out  32  read result, valid from ack until next ack

Behaviour:
- Reset (async, i_rst_n low):
  - state IDLE, bit counter 0, pending-core flags cleared.
  - o_dbg_ack 0, o_dbg_rdata 0, o_rf_rreq 0, o_rf_wreq 0.
  - Owner = CORE, so RF-side outputs are the combinational pass-through of core inputs.
- States: IDLE, DREQ, DWAIT, DSHIFT, DACK.
- IDLE, owner CORE:
  - Core signals pass straight through: rreq/wreq/addresses/wen/wdata to RF; i_rf_ready to o_core_ready; i_rdata0/1 to o_core_rdata0/1.
  - A debug access is accepted only if i_dbg_req & !i_core_active & !i_core_rreq & !i_core_wreq & no pending core request.
  - Core wins any same-cycle tie.
  - On accept: latch we/addr/wdata, go to DREQ.
- DREQ, owner DBG:
  - Assert o_rf_wreq (we=1) or o_rf_rreq (we=0) for exactly one cycle, then go to DWAIT.
- DWAIT:
  - Hold requests low; on i_rf_ready go to DSHIFT with counter 0.
  - i_rf_ready in the same cycle as the request is honoured.
- DSHIFT, 32 cycles, counter 0..31:
  - Read: o_rreg0 = latched addr; on each cycle shift i_rdata0 into bit [31] of a shift register, right-shifting, so the first bit lands in bit [0].
  - Write: o_wreg0 = addr; o_wdata0 = wdata[counter]; o_wen0 = 1, except when addr == 0 (x0), where o_wen0 stays 0 and the ack is still given.
  - Port 1: o_wen1 = 0, o_wreg1/o_rreg1 = 0.
  - After counter 31 go to DACK.
- DACK:
  - o_dbg_ack = 1 for one cycle; o_dbg_rdata updates this cycle (read only; unchanged on write).
  - Return to IDLE. The requester must drop i_dbg_req in the cycle after ack, or a new access begins.
- While owner is DBG (DREQ..DACK):
  - o_core_ready = 0; o_core_rdata0/1 = 0.
  - Core rreq/wreq pulses are latched as pending.
  - In the first IDLE cycle after DACK, pending requests are issued to RF as 1-cycle pulses, then cleared; read takes precedence, and write is issued the cycle after if both are pending.
- Counter is 5 bits and wraps naturally at 31 to 0 on leaving DSHIFT; no other wrap.
- Reset asserted mid-burst aborts immediately: no ack, partial RF write possible, and the next access starts clean.

Test Plan:
- Debug write addr 5, wdata 0xDEADBEEF, core idle, ready 2 cycles after wreq:
  - exactly one o_rf_wreq pulse;
  - 32 cycles of o_wen0=1, o_wreg0=5, bits 1,1,1,1,0,1,1,1...;
  - ack 1 cycle after the last bit.
- Debug read addr 34 (mepc, WITH_CSR=1), RF model returns 0x80000004 serially -> o_dbg_rdata = 0x80000004 at ack; o_wen0 stays 0 throughout.
- Debug write to addr 0 with 0xFFFFFFFF -> o_wen0 never asserts; ack still after 32 shift cycles.
- i_core_rreq and i_dbg_req asserted in the same idle cycle -> core request passes through; debug waits until i_core_active falls, then starts.
- Core wreq pulse arrives during DSHIFT -> o_core_ready held 0; o_rf_wreq re-issued in the first IDLE cycle after ack.
- i_rst_n pulsed low at counter 17 of a write -> o_wen0, o_dbg_ack and requests go 0 asynchronously; state IDLE; a subsequent read completes normally.
